// File: rtl/mor1kx_spr_dbg_master.sv
// Debug-side SPR bus initiator: one request in flight, bounded wait for the
// responder's ack, and a timeout that turns into an error response.
module mor1kx_spr_dbg_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [15:0] req_addr_i,
  input  logic [31:0] req_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        spr_access_o,
  output logic        spr_we_o,
  output logic        spr_re_o,
  output logic [15:0] spr_addr_o,
  output logic [31:0] spr_dat_o,
  output logic        spr_sys_mode_o,
  input  logic        spr_bus_ack_i,
  input  logic [31:0] spr_dat_i,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never depends on ready, and no output depends on inputs.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        we;
  logic [15:0] addr;
  logic [31:0] dat;
  logic [7:0]  wait_cnt;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      we       <= 1'b0;
      addr     <= '0;
      dat      <= '0;
      wait_cnt <= '0;
      rsp_dat  <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            we       <= req_we_i;
            addr     <= req_addr_i;
            dat      <= req_dat_i;
            wait_cnt <= '0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          // An ack on the terminal count still wins over the timeout.
          if (spr_bus_ack_i) begin
            rsp_dat <= we ? 32'd0 : spr_dat_i;
            rsp_err <= 1'b0;
            state   <= RESP;
          end else if (wait_cnt == LAST_WAIT) begin
            rsp_dat <= 32'd0;
            rsp_err <= 1'b1;
            state   <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_o    = (state == IDLE);
  assign spr_access_o   = (state == ACCESS);
  assign spr_we_o       = (state == ACCESS) & we;
  assign spr_re_o       = (state == ACCESS) & ~we;
  assign spr_sys_mode_o = (state == ACCESS);
  assign spr_addr_o     = addr;
  assign spr_dat_o      = dat;
  assign rsp_valid_o    = (state == RESP);
  assign rsp_dat_o      = rsp_dat;
  assign rsp_err_o      = rsp_err;
  assign dbg_state_o    = state;

endmodule

// File: tb/tb_mor1kx_spr_dbg_master.sv
// Directed bench: a default-timeout instance and a TIMEOUT_CYCLES=4 instance
// share all inputs; each test observes one of them through a select.
module tb_mor1kx_spr_dbg_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, rsp_ready, spr_bus_ack;
  logic [15:0] req_addr;
  logic [31:0] req_dat, spr_dat_in;

  logic        l_req_ready, l_rsp_valid, l_rsp_err, l_access, l_we, l_re, l_sys;
  logic [31:0] l_rsp_dat, l_spr_dat;
  logic [15:0] l_addr;
  logic [1:0]  l_state;
  logic        s_req_ready, s_rsp_valid, s_rsp_err, s_access, s_we, s_re, s_sys;
  logic [31:0] s_rsp_dat, s_spr_dat;
  logic [15:0] s_addr;
  logic [1:0]  s_state;

  logic        sel;
  logic        req_ready, rsp_valid, rsp_err, access, spr_we, spr_re, sys_mode;
  logic [31:0] rsp_dat, spr_dat_out;
  logic [15:0] spr_addr;

  int total = 0;
  int passed = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mor1kx_spr_dbg_master dut_long (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(l_req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_dat_i(req_dat),
    .rsp_valid_o(l_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(l_rsp_dat),
    .rsp_err_o(l_rsp_err), .spr_access_o(l_access), .spr_we_o(l_we), .spr_re_o(l_re),
    .spr_addr_o(l_addr), .spr_dat_o(l_spr_dat), .spr_sys_mode_o(l_sys),
    .spr_bus_ack_i(spr_bus_ack), .spr_dat_i(spr_dat_in), .dbg_state_o(l_state)
  );

  mor1kx_spr_dbg_master #(.TIMEOUT_CYCLES(4)) dut_short (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(s_req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_dat_i(req_dat),
    .rsp_valid_o(s_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(s_rsp_dat),
    .rsp_err_o(s_rsp_err), .spr_access_o(s_access), .spr_we_o(s_we), .spr_re_o(s_re),
    .spr_addr_o(s_addr), .spr_dat_o(s_spr_dat), .spr_sys_mode_o(s_sys),
    .spr_bus_ack_i(spr_bus_ack), .spr_dat_i(spr_dat_in), .dbg_state_o(s_state)
  );

  assign req_ready   = sel ? s_req_ready : l_req_ready;
  assign rsp_valid   = sel ? s_rsp_valid : l_rsp_valid;
  assign rsp_err     = sel ? s_rsp_err   : l_rsp_err;
  assign rsp_dat     = sel ? s_rsp_dat   : l_rsp_dat;
  assign access      = sel ? s_access    : l_access;
  assign spr_we      = sel ? s_we        : l_we;
  assign spr_re      = sel ? s_re        : l_re;
  assign sys_mode    = sel ? s_sys       : l_sys;
  assign spr_addr    = sel ? s_addr      : l_addr;
  assign spr_dat_out = sel ? s_spr_dat   : l_spr_dat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Pops the scoreboard's next expected read data and compares the response.
  task automatic check_rsp(input string tag, input logic exp_err);
    logic [31:0] exp_dat;
    exp_dat = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_dat"}, rsp_dat, exp_dat);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_both_idle();
    int n = 0;
    while (!(l_req_ready && s_req_ready) && n < 64) begin
      step();
      n++;
    end
    check("idle_wait", {31'd0, l_req_ready && s_req_ready}, 32'd1);
  endtask

  // Presents one request and returns in the first ACCESS cycle.
  task automatic issue(input logic we, input logic [15:0] addr, input logic [31:0] dat);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_dat   = dat;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    int seen;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_dat = '0;
    rsp_ready = 1'b1; spr_bus_ack = 1'b0; spr_dat_in = '0; sel = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Reset state
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_access", {31'd0, access}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_addr", {16'd0, spr_addr}, 32'd0);
    check("rst_spr_dat", spr_dat_out, 32'd0);

    // Read, same-cycle ack
    issue(1'b0, 16'h7800, 32'h1111_1111);
    check("rd_re", {31'd0, spr_re}, 32'd1);
    check("rd_we", {31'd0, spr_we}, 32'd0);
    check("rd_addr", {16'd0, spr_addr}, 32'h0000_7800);
    check("rd_req_ready", {31'd0, req_ready}, 32'd0);
    spr_bus_ack = 1'b1; spr_dat_in = 32'h0000_1234; exp_q.push_back(32'h0000_1234);
    step();
    spr_bus_ack = 1'b0;
    check("rd_re_one_cycle", {31'd0, spr_re}, 32'd0);
    check_rsp("rd", 1'b0);
    step();
    check("rd_back_idle", {31'd0, req_ready}, 32'd1);
    check("rd_rsp_gone", {31'd0, rsp_valid}, 32'd0);

    // Write, same-cycle ack; responder data must not leak into the response
    issue(1'b1, 16'h7808, 32'hDEAD_BEEF);
    check("wr_we", {31'd0, spr_we}, 32'd1);
    check("wr_re", {31'd0, spr_re}, 32'd0);
    check("wr_dat", spr_dat_out, 32'hDEAD_BEEF);
    check("wr_sys", {31'd0, sys_mode}, 32'd1);
    spr_bus_ack = 1'b1; spr_dat_in = 32'hFFFF_FFFF; exp_q.push_back(32'd0);
    step();
    spr_bus_ack = 1'b0;
    check_rsp("wr", 1'b0);
    check("wr_addr_kept", {16'd0, spr_addr}, 32'h0000_7808);
    step();

    // Delayed ack: five idle wait cycles, ack in the sixth
    wait_both_idle();
    issue(1'b0, 16'h0A05, 32'd0);
    for (int k = 0; k < 5; k++) begin
      spr_dat_in = 32'h0000_0100 + k;
      check("dly_access", {31'd0, access}, 32'd1);
      check("dly_addr", {16'd0, spr_addr}, 32'h0000_0A05);
      step();
    end
    check("dly_access6", {31'd0, access}, 32'd1);
    spr_bus_ack = 1'b1; spr_dat_in = 32'hCAFE_0005; exp_q.push_back(32'hCAFE_0005);
    step();
    spr_bus_ack = 1'b0; spr_dat_in = 32'h0;
    check_rsp("dly", 1'b0);
    step();

    // Timeout on the 4-cycle instance
    wait_both_idle();
    sel = 1'b1;
    issue(1'b0, 16'h5000, 32'd0);
    cyc = 0;
    while (access && cyc < 20) begin
      cyc++;
      step();
    end
    check("to_cycles", cyc, 32'd4);
    exp_q.push_back(32'd0);
    check_rsp("to", 1'b1);
    step();

    // Ack on the terminal count beats the timeout
    wait_both_idle();
    issue(1'b0, 16'h5004, 32'd0);
    repeat (3) step();
    check("to_ack_access", {31'd0, access}, 32'd1);
    spr_bus_ack = 1'b1; spr_dat_in = 32'h0000_0055; exp_q.push_back(32'h0000_0055);
    step();
    spr_bus_ack = 1'b0;
    check_rsp("to_ack", 1'b0);
    step();

    // Backpressure with a stray ack during RESP
    wait_both_idle();
    sel = 1'b0;
    rsp_ready = 1'b0;
    issue(1'b0, 16'h2000, 32'd0);
    spr_bus_ack = 1'b1; spr_dat_in = 32'h0BAD_0001;
    step();
    spr_bus_ack = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
    for (int k = 0; k < 10; k++) begin
      spr_bus_ack = (k == 3); spr_dat_in = 32'h0000_0777 + k;
      exp_q.push_back(32'h0BAD_0001);
      check_rsp("bp", 1'b0);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      step();
    end
    spr_bus_ack = 1'b0;
    rsp_ready = 1'b1;
    step();
    check("bp_next_ready", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    check("bp_next_access", {31'd0, access}, 32'd1);
    check("bp_next_addr", {16'd0, spr_addr}, 32'h0000_0010);
    spr_bus_ack = 1'b1; spr_dat_in = 32'h0000_0ABC; exp_q.push_back(32'h0000_0ABC);
    step();
    spr_bus_ack = 1'b0;
    check_rsp("bp_next", 1'b0);
    step();

    // Reset during the second wait cycle drops the request silently
    wait_both_idle();
    issue(1'b0, 16'h3000, 32'd0);
    step();
    check("mr_access_before", {31'd0, access}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mr_access", {31'd0, access}, 32'd0);
    check("mr_req_ready", {31'd0, req_ready}, 32'd1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) seen++;
      step();
    end
    check("mr_no_rsp", seen, 32'd0);
    issue(1'b0, 16'h3004, 32'd0);
    check("mr_new_access", {31'd0, spr_re}, 32'd1);
    spr_bus_ack = 1'b1; spr_dat_in = 32'h0000_4321; exp_q.push_back(32'h0000_4321);
    step();
    spr_bus_ack = 1'b0;
    check_rsp("mr_new", 1'b0);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
